// File: rtl/load_store_sequencer.sv
// rtl/load_store_sequencer.sv - splits CPU load/store requests into legal memory controller beats
module load_store_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [DATA_WIDTH-1:0] reqAddress,
    input  logic [DATA_WIDTH-1:0] reqData,
    input  logic [1:0]            reqLength,
    input  logic                  reqStore,
    input  logic                  reqLoad,
    input  logic                  reqUnsigned,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respData,
    output logic                  respError,
    output logic [DATA_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memDataWrite,
    output logic [1:0]            memLength,
    output logic                  memStore,
    output logic                  memLoad,
    output logic                  memUnsigned,
    input  logic [DATA_WIDTH-1:0] memDataRead
);
    localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic [1:0]            len_q, len_d;
    logic                  store_q, store_d, uns_q, uns_d, mis_q, mis_d, err_q, err_d;

    logic                  req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_len_q, mem_len_d;
    logic                  mem_store_q, mem_store_d, mem_load_q, mem_load_d;
    logic                  mem_uns_q, mem_uns_d;

    logic                  last_beat;
    logic [4:0]            rd_sh, wr_sh;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        len_d   = len_q;
        store_d = store_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        err_d   = err_q;

        last_beat = !mis_q || (beat_q == ((len_q == 2'd3) ? 2'd3 : 2'd1));
        rd_sh     = {beat_q, 3'b000};
        merged    = rdata_q;
        merged[rd_sh +: 8] = memDataRead[7:0];

        case (state_q)
            IDLE: begin
                if (reqValid && req_ready_q) begin
                    addr_d  = reqAddress;
                    data_d  = reqData;
                    len_d   = reqLength;
                    store_d = reqStore;
                    uns_d   = reqUnsigned;
                    mis_d   = (reqLength == 2'd1 && reqAddress[0]) ||
                              (reqLength == 2'd3 && reqAddress[1:0] != 2'b00);
                    err_d   = (reqLength == 2'd2) || (reqLoad == reqStore);
                    beat_d  = 2'd0;
                    wait_d  = '0;
                    rdata_d = '0;
                    state_d = err_d ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!store_q) begin
                    state_d = WAIT;
                    wait_d  = '0;
                end else if (last_beat) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            WAIT: begin
                if (wait_q == WW'(READ_LATENCY - 1)) begin
                    wait_d = '0;
                    // A misaligned half is finished here: extend from byte 1.
                    if (!mis_q)
                        rdata_d = memDataRead;
                    else if (last_beat && len_q == 2'd1)
                        rdata_d = {{16{merged[15] & ~uns_q}}, merged[15:0]};
                    else
                        rdata_d = merged;
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        resp_error_d = (state_d == DONE) && err_d;
        resp_data_d  = (state_d == DONE) ? rdata_d : '0;
        wr_sh        = {beat_d, 3'b000};
        mem_store_d  = 1'b0;
        mem_load_d   = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_len_d    = 2'd0;
        mem_uns_d    = 1'b0;
        if (state_d == ISSUE) begin
            mem_store_d = store_d;
            mem_load_d  = !store_d;
            mem_addr_d  = addr_d + DATA_WIDTH'(beat_d);
            mem_len_d   = mis_d ? 2'd0 : len_d;
            mem_uns_d   = mis_d ? 1'b1 : uns_d;
            mem_wdata_d = mis_d ? DATA_WIDTH'(data_d[wr_sh +: 8]) : data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            wait_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            rdata_q      <= '0;
            len_q        <= 2'd0;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            mis_q        <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_len_q    <= 2'd0;
            mem_store_q  <= 1'b0;
            mem_load_q   <= 1'b0;
            mem_uns_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rdata_q      <= rdata_d;
            len_q        <= len_d;
            store_q      <= store_d;
            uns_q        <= uns_d;
            mis_q        <= mis_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_data_q  <= resp_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_len_q    <= mem_len_d;
            mem_store_q  <= mem_store_d;
            mem_load_q   <= mem_load_d;
            mem_uns_q    <= mem_uns_d;
        end
    end

    assign reqReady     = req_ready_q;
    assign respValid    = resp_valid_q;
    assign respData     = resp_data_q;
    assign respError    = resp_error_q;
    assign memAddress   = mem_addr_q;
    assign memDataWrite = mem_wdata_q;
    assign memLength    = mem_len_q;
    assign memStore     = mem_store_q;
    assign memLoad      = mem_load_q;
    assign memUnsigned  = mem_uns_q;
endmodule
